// File: rtl/ltc_2656_pkg.sv
// ltc_2656_pkg: shared definitions for the LTC-2656 command sequencer.
//   - driver command encodings (CMD_*)
//   - LTC-2656 opcodes used by the sequencer (OP_*)
//   - sequencer FSM state type
//   - highest_set(): index of the highest set bit of a channel mask
package ltc_2656_pkg;

  localparam int unsigned MAX_CH = 8;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_XFER = 2'd1;
  localparam logic [1:0] CMD_LDAC = 2'd2;
  localparam logic [1:0] CMD_CLR  = 2'd3;

  localparam logic [3:0] OP_WRITE_INPUT      = 4'b0000;
  localparam logic [3:0] OP_WRITE_UPDATE_ALL = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE_XFER,
    S_WAIT_XFER,
    S_ISSUE_LDAC,
    S_WAIT_LDAC,
    S_ISSUE_CLR,
    S_WAIT_CLR,
    S_DONE
  } state_e;

  function automatic logic [2:0] highest_set(input logic [MAX_CH-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ltc_2656_shadow_regs.sv
// ltc_2656_shadow_regs: per-channel shadow codes and dirty bits.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   wr_en_i         host write strobe (channel >= NUM_CHANNELS ignored)
//   wr_channel_i    host write channel
//   wr_value_i      host write code
//   clr_all_i       zero every shadow code and dirty bit
//   clr_dirty_i     clear dirty bit of clr_idx_i
//   clr_idx_i       channel whose dirty bit is cleared
//   rd_idx_i        read address
//   rd_data_o       shadow code at rd_idx_i
//   dirty_o         dirty vector (bits >= NUM_CHANNELS always 0)
module ltc_2656_shadow_regs
  import ltc_2656_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_channel_i,
  input  logic [15:0]       wr_value_i,
  input  logic              clr_all_i,
  input  logic              clr_dirty_i,
  input  logic [2:0]        clr_idx_i,
  input  logic [2:0]        rd_idx_i,
  output logic [15:0]       rd_data_o,
  output logic [MAX_CH-1:0] dirty_o
);

  logic [15:0]       data_q  [MAX_CH];
  logic [15:0]       data_d  [MAX_CH];
  logic [MAX_CH-1:0] dirty_q;
  logic [MAX_CH-1:0] dirty_d;
  logic              wr_ok;

  assign wr_ok = wr_en_i && ({1'b0, wr_channel_i} < 4'(NUM_CHANNELS));

  // A host write is applied after clear/dirty-clear so it always wins for
  // its own channel: its value is kept and its dirty bit stays set.
  always_comb begin
    data_d  = data_q;
    dirty_d = dirty_q;
    if (clr_all_i) begin
      for (int unsigned i = 0; i < MAX_CH; i++) data_d[i] = '0;
      dirty_d = '0;
    end else if (clr_dirty_i) begin
      dirty_d[clr_idx_i] = 1'b0;
    end
    if (wr_ok) begin
      data_d[wr_channel_i]  = wr_value_i;
      dirty_d[wr_channel_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_CH; i++) data_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      data_q  <= data_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_data_o = data_q[rd_idx_i];
  assign dirty_o   = dirty_q;

endmodule

// File: rtl/ltc_2656_sequencer.sv
// ltc_2656_sequencer: streams dirty shadow channels to the LTC-2656 SPI
// driver as one-cycle commands, then pulses LDAC; also forwards clears.
// Optional build macro: LTC2656_SEQ_SPI_UPDATE_EN -- the last XFER of a
// pass uses "write n, update all" and no LDAC command is generated.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wr_en/wr_channel/wr_value  host shadow write
//   update, clear       request strobes (latched as pending flags)
//   busy                FSM not idle
//   done                one-cycle pulse at end of an update/clear pass
//   dac_idle            driver idle
//   dac_cmd/dac_channel/dac_value/command  registered driver command
module ltc_2656_sequencer
  import ltc_2656_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter bit          SEND_ALL     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_channel,
  input  logic [15:0] wr_value,
  input  logic        update,
  input  logic        clear,
  output logic        busy,
  output logic        done,
  input  logic        dac_idle,
  output logic [3:0]  dac_cmd,
  output logic [3:0]  dac_channel,
  output logic [15:0] dac_value,
  output logic [1:0]  command
);

  localparam logic [3:0] NCH  = 4'(NUM_CHANNELS);
  localparam logic [3:0] LAST = 4'(NUM_CHANNELS - 1);

  state_e      state_q, state_d, pass_end_state;
  logic [3:0]  ptr_q, ptr_d;
  logic        sent_any_q, sent_any_d;
  logic        upd_pend_q, clr_pend_q;
  logic        upd_start, clr_start;
  logic [1:0]  command_q, command_d;
  logic [3:0]  dac_cmd_q, dac_cmd_d;
  logic [3:0]  dac_channel_q, dac_channel_d;
  logic [15:0] dac_value_q, dac_value_d;
  logic        clr_all, clr_dirty, in_range;
  logic [15:0] rd_data;
  logic [MAX_CH-1:0] dirty;
`ifdef LTC2656_SEQ_SPI_UPDATE_EN
  logic [2:0]  last_idx_q, last_idx_d;
`endif

  ltc_2656_shadow_regs #(.NUM_CHANNELS(NUM_CHANNELS)) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (wr_en),
    .wr_channel_i(wr_channel),
    .wr_value_i  (wr_value),
    .clr_all_i   (clr_all),
    .clr_dirty_i (clr_dirty),
    .clr_idx_i   (ptr_q[2:0]),
    .rd_idx_i    (ptr_q[2:0]),
    .rd_data_o   (rd_data),
    .dirty_o     (dirty)
  );

`ifdef LTC2656_SEQ_SPI_UPDATE_EN
  // Channels above last_idx written mid-pass are left dirty for the next
  // pass so nothing is written after the update-all transfer.
  assign in_range       = (ptr_q < NCH) && (ptr_q <= {1'b0, last_idx_q});
  assign pass_end_state = S_DONE;
`else
  assign in_range       = (ptr_q < NCH);
  assign pass_end_state = sent_any_q ? S_ISSUE_LDAC : S_DONE;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sent_any_d    = sent_any_q;
    command_d     = CMD_NONE;
    dac_cmd_d     = dac_cmd_q;
    dac_channel_d = dac_channel_q;
    dac_value_d   = dac_value_q;
    upd_start     = 1'b0;
    clr_start     = 1'b0;
    clr_all       = 1'b0;
    clr_dirty     = 1'b0;
`ifdef LTC2656_SEQ_SPI_UPDATE_EN
    last_idx_d    = last_idx_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          clr_start = 1'b1;
          state_d   = S_ISSUE_CLR;
        end else if (upd_pend_q) begin
          upd_start  = 1'b1;
          ptr_d      = '0;
          sent_any_d = 1'b0;
          state_d    = S_SCAN;
`ifdef LTC2656_SEQ_SPI_UPDATE_EN
          last_idx_d = SEND_ALL ? LAST[2:0] : highest_set(dirty);
`endif
        end
      end
      // ptr may reach NUM_CHANNELS after the last XFER; the pass then ends
      // here. A clean last channel ends the pass in the same scan cycle.
      S_SCAN: begin
        if (in_range && (dirty[ptr_q[2:0]] || SEND_ALL)) state_d = S_ISSUE_XFER;
        else if (ptr_q >= LAST)                        state_d = pass_end_state;
        else                                           ptr_d   = ptr_q + 4'd1;
      end
      S_ISSUE_XFER: begin
        if (dac_idle) begin
          command_d     = CMD_XFER;
          dac_cmd_d     = OP_WRITE_INPUT;
`ifdef LTC2656_SEQ_SPI_UPDATE_EN
          if (ptr_q[2:0] == last_idx_q) dac_cmd_d = OP_WRITE_UPDATE_ALL;
`endif
          dac_channel_d = {1'b0, ptr_q[2:0]};
          dac_value_d   = rd_data;
          clr_dirty     = 1'b1;
          sent_any_d    = 1'b1;
          state_d       = S_WAIT_XFER;
        end
      end
      // command_q is non-zero exactly in the first wait cycle, which masks
      // the stale dac_idle before the driver has reacted.
      S_WAIT_XFER: begin
        if (command_q == CMD_NONE && dac_idle) begin
          ptr_d   = ptr_q + 4'd1;
          state_d = S_SCAN;
        end
      end
      S_ISSUE_LDAC: begin
        if (dac_idle) begin
          command_d = CMD_LDAC;
          state_d   = S_WAIT_LDAC;
        end
      end
      S_WAIT_LDAC: begin
        if (command_q == CMD_NONE && dac_idle) state_d = S_DONE;
      end
      S_ISSUE_CLR: begin
        if (dac_idle) begin
          command_d = CMD_CLR;
          clr_all   = 1'b1;
          state_d   = S_WAIT_CLR;
        end
      end
      S_WAIT_CLR: begin
        if (command_q == CMD_NONE && dac_idle) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      sent_any_q    <= 1'b0;
      upd_pend_q    <= 1'b0;
      clr_pend_q    <= 1'b0;
      command_q     <= CMD_NONE;
      dac_cmd_q     <= '0;
      dac_channel_q <= '0;
      dac_value_q   <= '0;
`ifdef LTC2656_SEQ_SPI_UPDATE_EN
      last_idx_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sent_any_q    <= sent_any_d;
      // A strobe coinciding with its pass start stays pending (set wins).
      upd_pend_q    <= (upd_pend_q && !upd_start) || update;
      clr_pend_q    <= (clr_pend_q && !clr_start) || clear;
      command_q     <= command_d;
      dac_cmd_q     <= dac_cmd_d;
      dac_channel_q <= dac_channel_d;
      dac_value_q   <= dac_value_d;
`ifdef LTC2656_SEQ_SPI_UPDATE_EN
      last_idx_q    <= last_idx_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign command     = command_q;
  assign dac_cmd     = dac_cmd_q;
  assign dac_channel = dac_channel_q;
  assign dac_value   = dac_value_q;

endmodule

// File: tb/tb_ltc_2656_sequencer.sv
// tb_ltc_2656_sequencer: directed self-checking bench for ltc_2656_sequencer
// with a small SPI-driver busy model on dac_idle.
module tb_ltc_2656_sequencer;
  import ltc_2656_pkg::*;

  localparam int NCH = 8;

  logic        clk = 1'b0;
  logic        reset, wr_en, update, clear, dac_idle;
  logic [2:0]  wr_channel;
  logic [15:0] wr_value;
  logic        busy, done;
  logic [3:0]  dac_cmd, dac_channel;
  logic [15:0] dac_value;
  logic [1:0]  command;

  typedef struct packed {
    logic [1:0]  c;
    logic [3:0]  op;
    logic [3:0]  ch;
    logic [15:0] v;
  } ev_t;

  ev_t  log_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  logic [1:0] prev_cmd = CMD_NONE;
  logic hold_low = 1'b0;

  ltc_2656_sequencer #(.NUM_CHANNELS(NCH), .SEND_ALL(1'b0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_channel(wr_channel),
    .wr_value(wr_value), .update(update), .clear(clear), .busy(busy),
    .done(done), .dac_idle(dac_idle), .dac_cmd(dac_cmd),
    .dac_channel(dac_channel), .dac_value(dac_value), .command(command)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver model: goes busy for 4 cycles after it samples a command.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) busy_cnt <= 0;
    else if (command != CMD_NONE) busy_cnt <= 4;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign dac_idle = (busy_cnt == 0) && !hold_low;

  always @(negedge clk) begin
    if (!reset) begin
      if (command != CMD_NONE) begin
        check_eq("cmd_one_cycle", 32'(prev_cmd), 32'(CMD_NONE));
        log_q.push_back('{command, dac_cmd, dac_channel, dac_value});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_cmd = command;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] ch, input logic [15:0] val);
    wr_en = 1'b1; wr_channel = ch; wr_value = val;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_dones(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    check_eq(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_ev(input string tag, input int idx, input ev_t exp);
    if (log_q.size() > idx) check_eq(tag, 32'(log_q[idx]), 32'(exp));
    else                    check_eq(tag, 32'(log_q.size()), 32'(idx + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, upd_cyc;
    reset = 1'b1; wr_en = 1'b0; wr_channel = '0; wr_value = '0;
    update = 1'b0; clear = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_command", 32'(command), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dac_cmd", 32'(dac_cmd), 32'd0);
    check_eq("rst_dac_channel", 32'(dac_channel), 32'd0);
    check_eq("rst_dac_value", 32'(dac_value), 32'd0);
    reset = 1'b0;
    tick();

    // Two dirty channels, then update.
    write(3'd2, 16'h1234);
    write(3'd5, 16'hBEEF);
    log_q.delete();
    base = done_cnt;
    pulse_update();
    wait_dones("t1_done", base + 1, 200);
    repeat (5) tick();
    check_eq("t1_ncmds", 32'(log_q.size()), 32'd3);
    check_ev("t1_xfer0", 0, '{CMD_XFER, 4'h0, 4'd2, 16'h1234});
    check_ev("t1_xfer1", 1, '{CMD_XFER, 4'h0, 4'd5, 16'hBEEF});
    if (log_q.size() > 2) check_eq("t1_ldac", 32'(log_q[2].c), 32'(CMD_LDAC));
    else                  check_eq("t1_ldac", 32'(log_q.size()), 32'd3);
    check_eq("t1_ndone", 32'(done_cnt - base), 32'd1);
    check_eq("t1_dirty", 32'(dut.u_shadow.dirty_o), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // Update with nothing dirty: no commands, done after NCH+2 cycles.
    log_q.delete();
    base = done_cnt;
    upd_cyc = cyc;
    pulse_update();
    wait_dones("t2_done", base + 1, 100);
    check_eq("t2_ncmds", 32'(log_q.size()), 32'd0);
    check_eq("t2_latency", 32'(done_cyc - upd_cyc), 32'(NCH + 2));

    // dac_idle held low for 100 cycles after the first XFER.
    write(3'd1, 16'h1111);
    write(3'd6, 16'h6666);
    log_q.delete();
    base = done_cnt;
    pulse_update();
    for (int i = 0; i < 50 && log_q.size() == 0; i++) tick();
    hold_low = 1'b1;
    repeat (100) tick();
    check_eq("t3_stalled", 32'(log_q.size()), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd1);
    hold_low = 1'b0;
    wait_dones("t3_done", base + 1, 200);
    check_ev("t3_xfer0", 0, '{CMD_XFER, 4'h0, 4'd1, 16'h1111});
    check_ev("t3_xfer1", 1, '{CMD_XFER, 4'h0, 4'd6, 16'h6666});

    // Write ch3 in the same cycle its XFER is issued.
    write(3'd3, 16'h0AAA);
    log_q.delete();
    base = done_cnt;
    pulse_update();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dut.state_q == S_ISSUE_XFER && dut.ptr_q == 4'd3 && dac_idle) break;
    end
    wr_en = 1'b1; wr_channel = 3'd3; wr_value = 16'h0001;
    tick();
    wr_en = 1'b0;
    wait_dones("t4_done_a", base + 1, 200);
    check_ev("t4_old_value", 0, '{CMD_XFER, 4'h0, 4'd3, 16'h0AAA});
    check_eq("t4_dirty_kept", 32'(dut.u_shadow.dirty_o), 32'h08);
    log_q.delete();
    pulse_update();
    wait_dones("t4_done_b", base + 2, 200);
    check_ev("t4_new_value", 0, '{CMD_XFER, 4'h0, 4'd3, 16'h0001});
    check_eq("t4_ncmds", 32'(log_q.size()), 32'd2);

    // clear and update together: CLR first, then a clean update pass.
    write(3'd0, 16'h0F0F);
    log_q.delete();
    base = done_cnt;
    clear = 1'b1; update = 1'b1;
    tick();
    clear = 1'b0; update = 1'b0;
    wait_dones("t5_done", base + 2, 200);
    repeat (5) tick();
    check_eq("t5_ncmds", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check_eq("t5_clr", 32'(log_q[0].c), 32'(CMD_CLR));
    else                  check_eq("t5_clr", 32'(log_q.size()), 32'd1);
    check_eq("t5_ndone", 32'(done_cnt - base), 32'd2);
    check_eq("t5_dirty", 32'(dut.u_shadow.dirty_o), 32'd0);

    // Reset during S_WAIT_XFER.
    write(3'd4, 16'h4444);
    write(3'd7, 16'h7777);
    pulse_update();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dut.state_q == S_WAIT_XFER) break;
    end
    check_eq("t6_in_wait", 32'(dut.state_q == S_WAIT_XFER), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("t6_command", 32'(command), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_dirty", 32'(dut.u_shadow.dirty_o), 32'd0);
    check_eq("t6_value", 32'(dac_value), 32'd0);
    reset = 1'b0;
    tick();
    log_q.delete();
    base = done_cnt;
    pulse_update();
    wait_dones("t6_done", base + 1, 100);
    check_eq("t6_ncmds", 32'(log_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
